// File: rtl/mips_arb_pkg.sv
// Shared types and constants for the MIPS single-port memory arbiter.
// Optional feature macro used by the arbiter: MIPS_ARB_TIMEOUT_EN.
package mips_arb_pkg;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 32'd1024;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_DATA  = 2'd1,
    ST_STEP  = 2'd2,
    ST_HALT  = 2'd3
  } arb_state_t;

  // An access completes on an edge where a strobe is up and the memory is not stalling.
  function automatic logic access_done(input logic strobe, input logic waitreq);
    return strobe & ~waitreq;
  endfunction

endpackage

// File: rtl/mips_arb_watchdog.sv
// Consecutive-stall watchdog for the arbiter; only instantiated when
// MIPS_ARB_TIMEOUT_EN is defined.
module mips_arb_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 32'd1024
) (
  input  logic clk,
  input  logic reset,
  input  logic busy,
  input  logic clear,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count_r;

  // Fires on the stall cycle that brings the consecutive count to TIMEOUT_CYCLES.
  assign expire = busy & (count_r == CW'(TIMEOUT_CYCLES - 1));

  // Count stalled cycles; any completion, idle cycle or state change restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= '0;
    end else if (!busy || clear || expire) begin
      count_r <= '0;
    end else begin
      count_r <= count_r + 1'b1;
    end
  end

endmodule

// File: rtl/mips_mem_arbiter.sv
// Sequences instruction fetch, data access and a single CPU clock-enable step
// over one shared single-port memory.
// Optional feature: define MIPS_ARB_TIMEOUT_EN to add a stall watchdog that
// raises timeout and halts after TIMEOUT_CYCLES consecutive stalled cycles.
import mips_arb_pkg::*;

module mips_mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_active,
  input  logic [31:0] instr_address,
  output logic [31:0] instr_readdata,
  input  logic [31:0] data_address,
  input  logic [31:0] data_writedata,
  input  logic        data_read,
  input  logic        data_write,
  output logic [31:0] data_readdata,
  output logic        clk_enable,
  output logic [31:0] mem_address,
  output logic [31:0] mem_writedata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_readdata,
  input  logic        mem_waitrequest,
  output logic        halted,
  output logic        proto_err,
  output logic        timeout
);

  arb_state_t  state_r;
  arb_state_t  next_state;
  arb_state_t  next_base;
  logic [31:0] instr_r;
  logic [31:0] data_r;
  logic        proto_err_r;
  logic        done;
  logic        expire;

  // Memory request and CPU clock enable decoded from the current state; reset
  // forces the CPU enable on so it observes reset edges, and drops all strobes.
  always_comb begin
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_address   = 32'h0000_0000;
    mem_writedata = 32'h0000_0000;
    clk_enable    = 1'b0;
    if (reset) begin
      clk_enable = 1'b1;
    end else begin
      case (state_r)
        ST_FETCH: begin
          mem_read    = 1'b1;
          mem_address = instr_address;
        end
        ST_DATA: begin
          if (data_write) begin
            mem_write     = 1'b1;
            mem_address   = data_address;
            mem_writedata = data_writedata;
          end else if (data_read) begin
            mem_read    = 1'b1;
            mem_address = data_address;
          end else begin
            mem_read = 1'b0;
          end
        end
        ST_STEP: clk_enable = 1'b1;
        ST_HALT: clk_enable = 1'b0;
        default: clk_enable = 1'b0;
      endcase
    end
  end

  assign done = access_done(mem_read | mem_write, mem_waitrequest);

  // Next-state selection; a watchdog expiry overrides normal sequencing.
  always_comb begin
    next_base = state_r;
    case (state_r)
      ST_FETCH: next_base = done ? ST_DATA : ST_FETCH;
      ST_DATA: begin
        if (!data_read && !data_write) begin
          next_base = ST_STEP;
        end else begin
          next_base = done ? ST_STEP : ST_DATA;
        end
      end
      ST_STEP: next_base = cpu_active ? ST_FETCH : ST_HALT;
      ST_HALT: next_base = ST_HALT;
      default: next_base = ST_FETCH;
    endcase
    if (expire) begin
      next_state = ST_HALT;
    end else begin
      next_state = next_base;
    end
  end

  // State register plus read-data latches and the sticky protocol-error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_FETCH;
      instr_r     <= 32'h0000_0000;
      data_r      <= 32'h0000_0000;
      proto_err_r <= 1'b0;
    end else begin
      state_r <= next_state;
      if (state_r == ST_FETCH && done) begin
        instr_r <= mem_readdata;
      end
      if (state_r == ST_DATA && mem_read && done) begin
        data_r <= mem_readdata;
      end
      if (state_r == ST_DATA && data_read && data_write) begin
        proto_err_r <= 1'b1;
      end
    end
  end

  assign instr_readdata = reset ? 32'h0000_0000 : instr_r;
  assign data_readdata  = reset ? 32'h0000_0000 : data_r;
  assign proto_err      = proto_err_r & ~reset;
  assign halted         = (state_r == ST_HALT) & ~reset;

`ifdef MIPS_ARB_TIMEOUT_EN
  logic timeout_r;

  mips_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk   (clk),
    .reset (reset),
    .busy  ((mem_read | mem_write) & mem_waitrequest),
    .clear (next_state != state_r),
    .expire(expire)
  );

  // Sticky timeout flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      timeout_r <= 1'b0;
    end else if (expire) begin
      timeout_r <= 1'b1;
    end else begin
      timeout_r <= timeout_r;
    end
  end

  assign timeout = timeout_r & ~reset;
`else
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

endmodule
